// File: rtl/qoi_pkg.sv
// rtl/qoi_pkg.sv - shared constants and types for the QOI chunk decoder
// Purpose: opcode constants, FSM state enum, register map, pixel struct.
// Ports: none (package).
package qoi_pkg;

  localparam logic [7:0] OP_RGB  = 8'hFE;
  localparam logic [7:0] OP_RGBA = 8'hFF;

  localparam logic [1:0] TAG_INDEX = 2'b00;
  localparam logic [1:0] TAG_DIFF  = 2'b01;
  localparam logic [1:0] TAG_LUMA  = 2'b10;
  localparam logic [1:0] TAG_RUN   = 2'b11;

  typedef enum logic [2:0] {
    ST_OP   = 3'd0,
    ST_ARG1 = 3'd1,
    ST_ARG2 = 3'd2,
    ST_ARG3 = 3'd3,
    ST_ARG4 = 3'd4,
    ST_EMIT = 3'd5
  } state_e;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_R      = 3'd1;
  localparam logic [2:0] REG_G      = 3'd2;
  localparam logic [2:0] REG_B      = 3'd3;
  localparam logic [2:0] REG_A      = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_CNT_LO = 3'd6;
  localparam logic [2:0] REG_CNT_HI = 3'd7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  localparam rgba_t PX_RESET = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

endpackage

// File: rtl/qoi_index.sv
// rtl/qoi_index.sv - 64-entry recently-seen pixel table
// Purpose: holds the 64x32 index array; the write slot is chosen by the
//          QOI hash of the written pixel.
// Ports: clk, rst_n (async, active-low), clear (sync wipe), wr_en/wr_px
//        (hashed write port), rd_idx/rd_px (combinational read port).
module qoi_index
  import qoi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_en,
  input  rgba_t      wr_px,
  input  logic [5:0] rd_idx,
  output rgba_t      rd_px
);

  rgba_t      mem [64];
  logic [5:0] wr_hash;

  // Only the low 6 bits of each channel influence a mod-64 result.
  always_comb begin
    wr_hash = wr_px.r[5:0] * 6'd3 + wr_px.g[5:0] * 6'd5
            + wr_px.b[5:0] * 6'd7 + wr_px.a[5:0] * 6'd11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_hash] <= wr_px;
    end
  end

  assign rd_px = mem[rd_idx];

endmodule

// File: rtl/qoi_decoder.sv
// rtl/qoi_decoder.sv - register-mapped QOI chunk decoder
// Purpose: firmware writes QOI chunk bytes to DATA; each decoded pixel is
//          held with a repeat count until popped through CTRL.
// Ports: clk, rst_n (async, active-low), cs/we/addr/data_i (register
//        write bus), data_o (combinational read data).
module qoi_decoder
  import qoi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  state_e      state;
  state_e      st_nxt;
  rgba_t       pixel;
  rgba_t       px_new;
  rgba_t       idx_rd;
  logic [7:0]  lat_op;
  logic [7:0]  lat_a1;
  logic [7:0]  lat_a2;
  logic [7:0]  lat_a3;
  logic [7:0]  run_rem;
  logic [7:0]  run_new;
  logic [15:0] pix_count;
  logic        ovf;
  logic        px_valid;
  logic        emit;

  logic       data_wr;
  logic       ctrl_wr;
  logic       take;
  logic       pop;
  logic       sclr;
  logic [7:0] dg;
  logic [7:0] dr;
  logic [7:0] db;

  assign data_wr = cs && we && (addr == REG_DATA);
  assign ctrl_wr = cs && we && (addr == REG_CTRL);
  assign take    = data_wr && !px_valid;
  assign pop     = ctrl_wr && data_i[0] && px_valid;
  assign sclr    = ctrl_wr && data_i[1];

  // LUMA: green bias is in the op byte (latched), red/blue nibbles in the arg.
  assign dg = {2'b00, lat_op[5:0]} - 8'd32;
  assign dr = dg - 8'd8 + {4'b0000, data_i[7:4]};
  assign db = dg - 8'd8 + {4'b0000, data_i[3:0]};

  // Decode of the byte being written this cycle; only acted on when take=1.
  always_comb begin
    emit    = 1'b0;
    px_new  = pixel;
    run_new = 8'd1;
    st_nxt  = state;
    case (state)
      ST_OP: begin
        if (data_i == OP_RGB || data_i == OP_RGBA) begin
          st_nxt = ST_ARG1;
        end else begin
          case (data_i[7:6])
            TAG_INDEX: begin
              emit   = 1'b1;
              px_new = idx_rd;
            end
            TAG_DIFF: begin
              emit     = 1'b1;
              px_new.r = pixel.r + {6'b0, data_i[5:4]} - 8'd2;
              px_new.g = pixel.g + {6'b0, data_i[3:2]} - 8'd2;
              px_new.b = pixel.b + {6'b0, data_i[1:0]} - 8'd2;
            end
            TAG_LUMA: st_nxt = ST_ARG1;
            default: begin
              emit    = 1'b1;
              run_new = {2'b00, data_i[5:0]} + 8'd1;
            end
          endcase
        end
      end
      ST_ARG1: begin
        if (lat_op != OP_RGB && lat_op != OP_RGBA) begin
          emit     = 1'b1;
          px_new.r = pixel.r + dr;
          px_new.g = pixel.g + dg;
          px_new.b = pixel.b + db;
        end else begin
          st_nxt = ST_ARG2;
        end
      end
      ST_ARG2: st_nxt = ST_ARG3;
      ST_ARG3: begin
        if (lat_op == OP_RGB) begin
          emit   = 1'b1;
          px_new = '{r: lat_a1, g: lat_a2, b: data_i, a: pixel.a};
        end else begin
          st_nxt = ST_ARG4;
        end
      end
      ST_ARG4: begin
        emit   = 1'b1;
        px_new = '{r: lat_a1, g: lat_a2, b: lat_a3, a: data_i};
      end
      default: st_nxt = state;
    endcase
    if (emit) st_nxt = ST_EMIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OP;
      pixel     <= PX_RESET;
      lat_op    <= '0;
      lat_a1    <= '0;
      lat_a2    <= '0;
      lat_a3    <= '0;
      run_rem   <= '0;
      pix_count <= '0;
      ovf       <= 1'b0;
      px_valid  <= 1'b0;
    end else if (sclr) begin
      state     <= ST_OP;
      pixel     <= PX_RESET;
      lat_op    <= '0;
      lat_a1    <= '0;
      lat_a2    <= '0;
      lat_a3    <= '0;
      run_rem   <= '0;
      pix_count <= '0;
      ovf       <= 1'b0;
      px_valid  <= 1'b0;
    end else begin
      if (data_wr && px_valid) ovf <= 1'b1;
      if (take) begin
        state <= st_nxt;
        case (state)
          ST_OP:   lat_op <= data_i;
          ST_ARG1: lat_a1 <= data_i;
          ST_ARG2: lat_a2 <= data_i;
          ST_ARG3: lat_a3 <= data_i;
          default: ;
        endcase
        if (emit) begin
          pixel    <= px_new;
          run_rem  <= run_new;
          px_valid <= 1'b1;
        end
      end
      if (pop) begin
        run_rem   <= run_rem - 8'd1;
        pix_count <= pix_count + 16'd1;
        if (run_rem == 8'd1) begin
          px_valid <= 1'b0;
          state    <= ST_OP;
        end
      end
    end
  end

  qoi_index u_index (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sclr),
    .wr_en  (take && emit),
    .wr_px  (px_new),
    .rd_idx (data_i[5:0]),
    .rd_px  (idx_rd)
  );

  always_comb begin
    data_o = 8'h00;
    case (addr)
      REG_DATA:   data_o = {5'b00000, ovf, px_valid, ~px_valid};
      REG_R:      data_o = pixel.r;
      REG_G:      data_o = pixel.g;
      REG_B:      data_o = pixel.b;
      REG_A:      data_o = pixel.a;
      REG_CTRL:   data_o = run_rem;
      REG_CNT_LO: data_o = pix_count[7:0];
      REG_CNT_HI: data_o = pix_count[15:8];
      default:    data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// tb/tb_qoi_decoder.sv - scoreboard bench for qoi_decoder
module tb_qoi_decoder;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;

  qoi_decoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int v;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   done;
  bit   final_done;

  // Reference model: pixel channels, index table, pending chunk bytes.
  int  m_px[4];
  int  m_idx[64][4];
  int  m_run;
  int  m_cnt;
  bit  m_valid;
  bit  m_ovf;
  int  m_pend[$];

  function automatic void m_reset();
    m_px = '{0, 0, 0, 255};
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++) m_idx[i][j] = 0;
    m_run = 0;
    m_cnt = 0;
    m_valid = 0;
    m_ovf = 0;
    m_pend.delete();
  endfunction

  function automatic int chunk_len(int op);
    if (op == 254) return 4;
    if (op == 255) return 5;
    if ((op >> 6) == 2) return 2;
    return 1;
  endfunction

  function automatic void m_data(int b);
    int op, dg, dr, db, h;
    if (m_valid) begin
      m_ovf = 1;
      return;
    end
    m_pend.push_back(b);
    if (m_pend.size() < chunk_len(m_pend[0])) return;
    op = m_pend[0];
    m_run = 1;
    if (op == 254) begin
      for (int c = 0; c < 3; c++) m_px[c] = m_pend[c+1];
    end else if (op == 255) begin
      for (int c = 0; c < 4; c++) m_px[c] = m_pend[c+1];
    end else begin
      case (op >> 6)
        0: for (int c = 0; c < 4; c++) m_px[c] = m_idx[op % 64][c];
        1: begin
          m_px[0] = (m_px[0] + ((op >> 4) & 3) - 2) & 255;
          m_px[1] = (m_px[1] + ((op >> 2) & 3) - 2) & 255;
          m_px[2] = (m_px[2] + (op & 3) - 2) & 255;
        end
        2: begin
          dg = (op & 63) - 32;
          dr = dg - 8 + (m_pend[1] >> 4);
          db = dg - 8 + (m_pend[1] & 15);
          m_px[0] = (m_px[0] + dr) & 255;
          m_px[1] = (m_px[1] + dg) & 255;
          m_px[2] = (m_px[2] + db) & 255;
        end
        default: m_run = (op & 63) + 1;
      endcase
    end
    h = (3*m_px[0] + 5*m_px[1] + 7*m_px[2] + 11*m_px[3]) % 64;
    for (int c = 0; c < 4; c++) m_idx[h][c] = m_px[c];
    m_valid = 1;
    m_pend.delete();
  endfunction

  function automatic void m_ctrl(int v);
    if ((v & 2) != 0) begin
      m_reset();
    end else if ((v & 1) != 0 && m_valid) begin
      m_run--;
      m_cnt = (m_cnt + 1) & 65535;
      if (m_run == 0) m_valid = 0;
    end
  endfunction

  function automatic int exp_read(int a);
    case (a)
      0: return (m_ovf ? 4 : 0) + (m_valid ? 2 : 1);
      1, 2, 3, 4: return m_px[a-1];
      5: return m_run;
      6: return m_cnt & 255;
      default: return (m_cnt >> 8) & 255;
    endcase
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    cs = 1'b0;
    we = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    @(posedge clk); #1;
    cs = 1'b1;
    we = 1'b1;
    addr = a[2:0];
    data_i = d[7:0];
    if (a == 0) m_data(d & 255);
    else if (a == 5) m_ctrl(d & 255);
  endtask

  task automatic rd(input int a);
    exp_t e;
    @(posedge clk); #1;
    cs = 1'b1;
    we = 1'b0;
    addr = a[2:0];
    data_i = 8'($urandom);
    e.a = a;
    e.v = exp_read(a);
    exp_q.push_back(e);
  endtask

  task automatic rd_all();
    for (int a = 0; a < 8; a++) rd(a);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cs = 1'b0;
    we = 1'b0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every read cycle the bus presents is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cs && !we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read addr%0d: got %02h, no expectation queued", addr, data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== 8'(e.v)) begin
          errors++;
          $display("FAIL read_addr%0d: got %02h expected %02h at %0t", e.a, data_o, 8'(e.v), $time);
        end
      end
    end
    if (done && !final_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end
      final_done = 1'b1;
    end
  end

  initial begin
    int r, b;
    checks = 0;
    errors = 0;
    done = 1'b0;
    final_done = 1'b0;
    cs = 1'b0;
    we = 1'b0;
    addr = '0;
    data_i = '0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    rd_all();

    // RGB chunk then pop
    wr(0, 'hFE); wr(0, 'h10); wr(0, 'h20); wr(0, 'h30);
    rd_all();
    wr(5, 1);
    rd(0); rd(6); rd(7);

    // DIFF wrap-around and LUMA
    wr(5, 2);
    wr(0, 'h40);
    rd_all();
    wr(5, 1);
    wr(0, 'hA8); wr(0, 'h88);
    rd_all();
    wr(5, 1);

    // RUN with overflow write, then drain
    wr(0, 'hC2);
    rd(5);
    wr(0, 'h00);
    rd(0);
    for (int i = 0; i < 3; i++) begin
      wr(5, 1);
      rd(5);
    end
    rd(0); rd(6);
    wr(5, 1);
    rd(0); rd(6);

    // INDEX recall of an earlier pixel
    wr(5, 2);
    wr(0, 'hFE); wr(0, 'h10); wr(0, 'h20); wr(0, 'h30); wr(5, 1);
    wr(0, 'hFE); wr(0, 'h00); wr(0, 'h00); wr(0, 'h00); wr(5, 1);
    wr(0, 'h15);
    rd_all();
    wr(0, 'h35);
    wr(5, 1);
    wr(0, 'h35);
    rd_all();
    wr(5, 1);

    // Reset mid-RGBA, then soft_clear+pop during a run
    wr(0, 'hFF); wr(0, 'h01);
    do_reset();
    rd_all();
    wr(0, 'hFF); wr(0, 'h11); wr(0, 'h22); wr(0, 'h33); wr(0, 'h44);
    rd_all();
    wr(5, 1);
    wr(0, 'hC2);
    wr(5, 3);
    rd_all();

    // Randomised traffic
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        wr(0, 'hFE);
        for (int k = 0; k < 3; k++) wr(0, $urandom_range(0, 255));
      end else if (r < 14) begin
        wr(0, 'hFF);
        for (int k = 0; k < 4; k++) wr(0, $urandom_range(0, 255));
      end else if (r < 50) begin
        b = $urandom_range(0, 255);
        if (b >= 'hC0 && b < 'hFE) b = 'hC0 | $urandom_range(0, 3);
        wr(0, b);
      end else if (r < 88) begin
        wr(5, 1);
      end else if (r < 90) begin
        wr(5, $urandom_range(2, 3));
      end else if (r < 91) begin
        do_reset();
      end else begin
        b = $urandom_range(1, 6);
        if (b == 5) b = 7;
        wr(b, $urandom_range(0, 255));
      end
      rd(0);
      rd($urandom_range(1, 7));
    end
    rd_all();

    idle();
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
